// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider; odd N uses a negedge half-cycle stage.
// Optional CLKDIV_TICK_EN adds a one-clk tick pulse per output period.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             load,
  output logic             clkout,
  output logic [WIDTH-1:0] div_active,
  output logic             busy
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [WIDTH-1:0] DEF_N = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           st, st_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, pending, half, div_clamp;
  logic             out_p, out_p_nxt, out_n, bnd;

  assign div_clamp = (div < WIDTH'(2)) ? WIDTH'(2) : div;
  // ceil(N/2) without the overflow (N+1)>>1 would hit at N = 2**WIDTH-1
  assign half      = (div_active >> 1) + WIDTH'(div_active[0]);
  // Idle behaves as a permanent period boundary: divisor applies and start is allowed
  assign bnd       = (st == IDLE) || (cnt == div_active - WIDTH'(1));

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt + WIDTH'(1);
    out_p_nxt = (cnt + WIDTH'(1)) < half;
    if (bnd) begin
      cnt_nxt   = '0;
      out_p_nxt = en;
      st_nxt    = en ? RUN : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      out_p      <= 1'b0;
      busy       <= 1'b0;
      div_active <= DEF_N;
      pending    <= DEF_N;
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      out_p <= out_p_nxt;
      if (load) pending <= div_clamp;
      // A load on the boundary cycle stays pending for the following boundary
      if (bnd) begin
        div_active <= pending;
        busy       <= load;
      end else begin
        busy <= busy | load;
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) out_n <= 1'b0;
    else     out_n <= out_p;
  end

  // div_active only changes at a boundary where out_p and out_n are both low
  assign clkout = div_active[0] ? (out_p & out_n) : out_p;

`ifdef CLKDIV_TICK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick <= 1'b0;
    else     tick <= bnd && en;
  end
`endif

endmodule
